// File: rtl/spm_axi_initiator_pkg.sv
// Shared types for the SPM AXI initiator: memory op tag for the order tracker
// and the narrow AXI4 request/response channel structs.
package spm_axi_initiator_pkg;

  localparam int unsigned AddrWidth = 48;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  localparam logic [2:0] AxiSize   = 3'($clog2(StrbWidth));
  localparam logic [1:0] BurstIncr = 2'b01;

  typedef enum logic {MemOpRead, MemOpWrite} mem_op_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

// File: rtl/spm_axi_initiator_fifo.sv
// Order tracker: remembers whether each issued transaction was a read or a
// write so responses can be returned in grant order.
module spm_axi_initiator_fifo
  import spm_axi_initiator_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push,
  input  mem_op_e push_op,
  input  logic    pop,
  output mem_op_e head_op,
  output logic    empty,
  output logic    full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  mem_op_e             mem_q [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     cnt_q;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_op = mem_q[rptr_q];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_op;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CntW'(Depth));
`endif

endmodule

// File: rtl/spm_axi_initiator.sv
// Converts an OBI-like single-word request stream into single-beat AXI4
// transactions, returning responses in grant order across reads and writes.
module spm_axi_initiator
  import spm_axi_initiator_pkg::*;
#(
  parameter logic [IdWidth-1:0] AxiId          = '0,
  parameter int unsigned        MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mem_req_i,
  output logic                 mem_gnt_o,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic                 mem_we_i,
  input  logic [DataWidth-1:0] mem_wdata_i,
  input  logic [StrbWidth-1:0] mem_strb_i,
  output logic                 mem_rvalid_o,
  output logic [DataWidth-1:0] mem_rdata_o,
  output logic                 mem_err_o,
  output logic                 busy_o,
  output axi_req_t             axi_req_o,
  input  axi_rsp_t             axi_rsp_i
);

  logic    aw_done_q, w_done_q;
  logic    full, empty;
  mem_op_e head_op;
  logic    ar_valid, aw_valid, w_valid, r_ready, b_ready;
  logic    ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic    rd_gnt, wr_gnt;
  logic    rsp_unused;

  // Request side: once one write channel has completed the slot is implicitly
  // reserved, since the count can only fall until this write is granted.
  assign ar_valid = mem_req_i & ~mem_we_i & ~full;
  assign aw_valid = mem_req_i &  mem_we_i & ~aw_done_q & (~full | w_done_q);
  assign w_valid  = mem_req_i &  mem_we_i & ~w_done_q  & (~full | aw_done_q);

  assign ar_hs = ar_valid & axi_rsp_i.ar_ready;
  assign aw_hs = aw_valid & axi_rsp_i.aw_ready;
  assign w_hs  = w_valid  & axi_rsp_i.w_ready;

  assign rd_gnt    = ar_hs;
  assign wr_gnt    = mem_req_i & mem_we_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign mem_gnt_o = rd_gnt | wr_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (wr_gnt) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_q | aw_hs;
      w_done_q  <= w_done_q  | w_hs;
    end
  end

  // Response side: only the channel matching the oldest outstanding op is ready.
  assign r_ready = ~empty & (head_op == MemOpRead);
  assign b_ready = ~empty & (head_op == MemOpWrite);
  assign r_hs    = r_ready & axi_rsp_i.r_valid;
  assign b_hs    = b_ready & axi_rsp_i.b_valid;

  assign mem_rvalid_o = r_hs | b_hs;
  assign mem_rdata_o  = r_hs ? axi_rsp_i.r.data : '0;
  assign mem_err_o    = r_hs ? axi_rsp_i.r.resp[1] : (b_hs & axi_rsp_i.b.resp[1]);
  assign busy_o       = ~empty;

  spm_axi_initiator_fifo #(
    .Depth (MaxOutstanding)
  ) i_order (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (mem_gnt_o),
    .push_op (mem_we_i ? MemOpWrite : MemOpRead),
    .pop     (mem_rvalid_o),
    .head_op (head_op),
    .empty   (empty),
    .full    (full)
  );

  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = AxiId;
    axi_req_o.aw.addr   = mem_addr_i;
    axi_req_o.aw.size   = AxiSize;
    axi_req_o.aw.burst  = BurstIncr;
    axi_req_o.aw_valid  = aw_valid;
    axi_req_o.w.data    = mem_wdata_i;
    axi_req_o.w.strb    = mem_strb_i;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.w_valid   = w_valid;
    axi_req_o.b_ready   = b_ready;
    axi_req_o.ar.id     = AxiId;
    axi_req_o.ar.addr   = mem_addr_i;
    axi_req_o.ar.size   = AxiSize;
    axi_req_o.ar.burst  = BurstIncr;
    axi_req_o.ar_valid  = ar_valid;
    axi_req_o.r_ready   = r_ready;
  end

  assign rsp_unused = ^{axi_rsp_i.b.id, axi_rsp_i.b.resp[0], axi_rsp_i.b.user,
                        axi_rsp_i.r.id, axi_rsp_i.r.resp[0], axi_rsp_i.r.last,
                        axi_rsp_i.r.user};

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_req_i && !mem_gnt_o |=> mem_req_i &&
      $stable({mem_we_i, mem_addr_i, mem_wdata_i, mem_strb_i}));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    ar_valid && !axi_rsp_i.ar_ready |=> ar_valid && $stable(axi_req_o.ar));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_valid && !axi_rsp_i.aw_ready |=> aw_valid && $stable(axi_req_o.aw));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_valid && !axi_rsp_i.w_ready |=> w_valid && $stable(axi_req_o.w));
`endif

endmodule

// File: tb/tb_spm_axi_initiator.sv
// Directed bench for spm_axi_initiator: ordering, back-pressure, full
// limit, error propagation and mid-operation reset.
module tb_spm_axi_initiator;
  import spm_axi_initiator_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req, we, gnt, rvalid, err, busy;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata, rdata;
  logic [StrbWidth-1:0] strb;
  axi_req_t             axi_req;
  axi_rsp_t             axi_rsp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spm_axi_initiator #(.AxiId('0), .MaxOutstanding(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_req_i    (req),
    .mem_gnt_o    (gnt),
    .mem_addr_i   (addr),
    .mem_we_i     (we),
    .mem_wdata_i  (wdata),
    .mem_strb_i   (strb),
    .mem_rvalid_o (rvalid),
    .mem_rdata_o  (rdata),
    .mem_err_o    (err),
    .busy_o       (busy),
    .axi_req_o    (axi_req),
    .axi_rsp_i    (axi_rsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    strb    = '0;
    axi_rsp = '0;
    #3;
    chk("rst_gnt",      64'(gnt), 64'd0);
    chk("rst_rvalid",   64'(rvalid), 64'd0);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_valids",   64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 64'd0);
    chk("rst_readys",   64'({axi_req.r_ready, axi_req.b_ready}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single read, R three cycles after grant
    req = 1'b1; we = 1'b0; addr = 48'h1000;
    axi_rsp.ar_ready = 1'b1;
    #1;
    chk("rd_gnt",      64'(gnt), 64'd1);
    chk("rd_ar_valid", 64'(axi_req.ar_valid), 64'd1);
    chk("rd_ar_addr",  64'(axi_req.ar.addr), 64'h1000);
    chk("rd_ar_fmt",   64'({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst}), {51'd0, 8'd0, 3'd3, 2'd1});
    tick();
    req = 1'b0; axi_rsp.ar_ready = 1'b0;
    #1;
    chk("rd_busy",     64'(busy), 64'd1);
    chk("rd_r_ready",  64'(axi_req.r_ready), 64'd1);
    chk("rd_no_rv",    64'(rvalid), 64'd0);
    tick();
    tick();
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'hDEAD_BEEF; axi_rsp.r.resp = 2'b00;
    #1;
    chk("rd_rvalid",   64'(rvalid), 64'd1);
    chk("rd_rdata",    rdata, 64'hDEAD_BEEF);
    chk("rd_err",      64'(err), 64'd0);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("rd_idle",     64'({busy, rvalid}), 64'd0);

    // write with W accepted three cycles after AW
    req = 1'b1; we = 1'b1; addr = 48'h2008; wdata = 64'h55; strb = 8'h01;
    axi_rsp.aw_ready = 1'b1;
    #1;
    chk("wr_c0_valids", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'b11);
    chk("wr_c0_gnt",    64'(gnt), 64'd0);
    chk("wr_aw_addr",   64'(axi_req.aw.addr), 64'h2008);
    for (int c = 1; c <= 2; c++) begin
      tick();
      chk("wr_wait_aw",  64'(axi_req.aw_valid), 64'd0);
      chk("wr_wait_w",   64'(axi_req.w_valid), 64'd1);
      chk("wr_wait_gnt", 64'(gnt), 64'd0);
    end
    tick();
    axi_rsp.w_ready = 1'b1;
    #1;
    chk("wr_c3_gnt",   64'(gnt), 64'd1);
    chk("wr_c3_aw",    64'(axi_req.aw_valid), 64'd0);
    chk("wr_w_fields", 64'({axi_req.w.strb, axi_req.w.last}), {55'd0, 8'h01, 1'b1});
    chk("wr_w_data",   axi_req.w.data, 64'h55);
    tick();
    req = 1'b0; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
    #1;
    chk("wr_b_ready",  64'({axi_req.b_ready, axi_req.r_ready}), 64'b10);
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b00;
    #1;
    chk("wr_rvalid",   64'(rvalid), 64'd1);
    chk("wr_rdata",    rdata, 64'd0);
    chk("wr_err",      64'(err), 64'd0);
    tick();
    axi_rsp.b_valid = 1'b0;

    // write then read; R arrives before B
    req = 1'b1; we = 1'b1; addr = 48'h3000; wdata = 64'h1234; strb = 8'hFF;
    axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    #1;
    chk("wr_both_gnt", 64'(gnt), 64'd1);
    tick();
    we = 1'b0; addr = 48'h4000;
    axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0; axi_rsp.ar_ready = 1'b1;
    #1;
    chk("rd2_gnt",     64'(gnt), 64'd1);
    tick();
    req = 1'b0; axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'hABCD;
    #1;
    chk("ord_r_block", 64'({axi_req.r_ready, axi_req.b_ready}), 64'b01);
    chk("ord_no_rv",   64'(rvalid), 64'd0);
    tick();
    chk("ord_r_held",  64'(axi_req.r_ready), 64'd0);
    axi_rsp.b_valid = 1'b1;
    #1;
    chk("ord_b_first", 64'({rvalid, err}), 64'b10);
    chk("ord_b_rdata", rdata, 64'd0);
    tick();
    axi_rsp.b_valid = 1'b0;
    #1;
    chk("ord_r_second", 64'({axi_req.r_ready, rvalid}), 64'b11);
    chk("ord_r_data",   rdata, 64'hABCD);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("ord_idle",    64'(busy), 64'd0);

    // fill to MaxOutstanding with reads
    axi_rsp.ar_ready = 1'b1; req = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 48'h5000 + 48'(i * 8);
      #1;
      chk("full_fill_gnt", 64'(gnt), 64'd1);
      tick();
    end
    addr = 48'h5020;
    #1;
    chk("full_ar_off", 64'({axi_req.ar_valid, gnt}), 64'd0);
    tick();
    chk("full_ar_off2", 64'({axi_req.ar_valid, gnt}), 64'd0);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h11;
    #1;
    chk("full_pop_rv",  64'(rvalid), 64'd1);
    chk("full_pop_gnt", 64'(gnt), 64'd0);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("full_regnt",  64'({axi_req.ar_valid, gnt}), 64'b11);
    tick();
    req = 1'b0; axi_rsp.ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h20 + 64'(i);
      #1;
      chk("drain_rv",    64'(rvalid), 64'd1);
      chk("drain_rdata", rdata, 64'h20 + 64'(i));
      tick();
    end
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("drain_idle",  64'(busy), 64'd0);

    // error responses
    req = 1'b1; we = 1'b0; addr = 48'h7000; axi_rsp.ar_ready = 1'b1;
    tick();
    req = 1'b0; axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.resp = 2'b10; axi_rsp.r.data = 64'h0;
    #1;
    chk("slverr",      64'({rvalid, err}), 64'b11);
    tick();
    axi_rsp.r_valid = 1'b0; axi_rsp.r.resp = 2'b00;
    req = 1'b1; we = 1'b1; addr = 48'h7008; axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    tick();
    req = 1'b0; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b11;
    #1;
    chk("decerr",      64'({rvalid, err}), 64'b11);
    tick();
    axi_rsp.b_valid = 1'b0; axi_rsp.b.resp = 2'b00;

    // reset with two reads outstanding
    req = 1'b1; we = 1'b0; addr = 48'h8000; axi_rsp.ar_ready = 1'b1;
    tick();
    addr = 48'h8008;
    tick();
    req = 1'b0; axi_rsp.ar_ready = 1'b0;
    #1;
    chk("mid_busy",    64'(busy), 64'd1);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h99;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out",  64'({rvalid, gnt, axi_req.r_ready, axi_req.b_ready, axi_req.ar_valid}), 64'd0);
    tick();
    rst_n = 1'b1; axi_rsp.r_valid = 1'b0;
    tick();
    req = 1'b1; we = 1'b0; addr = 48'h9000; axi_rsp.ar_ready = 1'b1;
    #1;
    chk("post_gnt",    64'(gnt), 64'd1);
    tick();
    req = 1'b0; axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'hCAFE;
    #1;
    chk("post_rv",     64'(rvalid), 64'd1);
    chk("post_rdata",  rdata, 64'hCAFE);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("post_idle",   64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
